cache_mem_arbiter: RTL



---
 rtl/cache_mem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one memory line port between I-cache and D-cache miss paths
// Optional ARB_ROUND_ROBIN_EN swaps fixed D priority plus starvation counter for round-robin.
module cache_mem_arbiter #(
    parameter int LINE_WIDTH   = 256,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   gnt_addr;
    logic                    gnt_we;
    logic [LINE_WIDTH-1:0]   gnt_wdata;
    logic                    i_pend, d_pend;
    logic                    grant_i, grant_d;
    logic                    pick_i_contended;
    logic                    busy;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // last_gnt: 0 = I was granted most recently, 1 = D
    logic last_gnt;

    assign pick_i_contended = last_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= 1'b0;
        end else if (grant_i) begin
            last_gnt <= 1'b0;
        end else if (grant_d) begin
            last_gnt <= 1'b1;
        end
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    assign pick_i_contended = (starve_cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (grant_d) begin
            if (!i_pend) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else if (grant_i) begin
            starve_cnt <= 4'd0;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (i_pend && (!d_pend || pick_i_contended)) begin
                    grant_i   = 1'b1;
                    state_nxt = SERVE_I;
                end else if (d_pend) begin
                    grant_d   = 1'b1;
                    state_nxt = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt_addr  <= '0;
            gnt_we    <= 1'b0;
            gnt_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (grant_i) begin
                gnt_addr  <= i_address;
                gnt_we    <= 1'b0;
                gnt_wdata <= '0;
            end else if (grant_d) begin
                gnt_addr  <= d_address;
                gnt_we    <= d_write;
                gnt_wdata <= d_wdata;
            end
        end
    end

    // Gating with reset keeps the reset cycle itself quiet even mid-transaction.
    assign busy         = (state != IDLE) && !reset;
    assign pmem_read    = busy && !gnt_we;
    assign pmem_write   = busy && gnt_we;
    assign pmem_address = gnt_addr;
    assign pmem_wdata   = gnt_wdata;
    assign i_resp       = !reset && (state == SERVE_I) && pmem_resp;
    assign d_resp       = !reset && (state == SERVE_D) && pmem_resp;
    assign i_rdata      = pmem_rdata;
    assign d_rdata      = pmem_rdata;

endmodule
